// File: rtl/imm_pkg.sv
// Shared definitions for the decode-stage immediate generator.
// Holds the immediate-format select encoding, the instruction bit-field
// positions the extractor slices, and the set of supported datapath widths.
package imm_pkg;

   typedef enum logic [2:0] {
      IMM_I   = 3'b000,
      IMM_ISH = 3'b001,
      IMM_S   = 3'b010,
      IMM_B   = 3'b011,
      IMM_U   = 3'b100,
      IMM_J   = 3'b101,
      IMM_CSR = 3'b110,
      IMM_ILL = 3'b111
   } imm_sel_e;

   localparam int INSTR_W     = 32;
   localparam int SIGN_BIT    = 31;
   localparam int I_IMM_LO    = 20;
   localparam int S_HI_LO     = 25;
   localparam int S_LO_HI     = 11;
   localparam int S_LO_LO     = 7;
   localparam int U_IMM_LO    = 12;
   localparam int SHAMT32_HI  = 24;
   localparam int SHAMT64_HI  = 25;
   localparam int SHAMT_LO    = 20;
   localparam int CSR_UIMM_HI = 19;
   localparam int CSR_UIMM_LO = 15;

   localparam int XLEN_RV32 = 32;
   localparam int XLEN_RV64 = 64;

   function automatic bit xlen_legal(input int xlen);
      return (xlen == XLEN_RV32) || (xlen == XLEN_RV64);
   endfunction

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extraction.
// Ports:
//   instr_i  full 32-bit instruction
//   sel_i    immediate format select
//   imm_o    immediate extended to XLEN
//   err_o    select was the illegal encoding
// Every format is first assembled as a 32-bit value whose bit 31 already
// carries the correct extension (instr[31] for signed formats, 0 for the
// zero-extended shift/CSR formats), so one signed widening covers RV64.
module imm_extract
   import imm_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [INSTR_W-1:0] instr_i,
   input  imm_sel_e           sel_i,
   output logic [XLEN-1:0]    imm_o,
   output logic               err_o
);

   logic                s;
   logic [INSTR_W-1:0]  raw;

   assign s = instr_i[SIGN_BIT];

   always_comb begin
      raw   = '0;
      err_o = 1'b0;
      case (sel_i)
         IMM_I:   raw = {{20{s}}, instr_i[SIGN_BIT:I_IMM_LO]};
         IMM_ISH: begin
            if (XLEN == XLEN_RV64) raw = {26'b0, instr_i[SHAMT64_HI:SHAMT_LO]};
            else                   raw = {27'b0, instr_i[SHAMT32_HI:SHAMT_LO]};
         end
         IMM_S:   raw = {{20{s}}, instr_i[SIGN_BIT:S_HI_LO], instr_i[S_LO_HI:S_LO_LO]};
         IMM_B:   raw = {{19{s}}, s, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
         IMM_U:   raw = {instr_i[SIGN_BIT:U_IMM_LO], 12'b0};
         IMM_J:   raw = {{11{s}}, s, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
         IMM_CSR: raw = {27'b0, instr_i[CSR_UIMM_HI:CSR_UIMM_LO]};
         IMM_ILL: begin
            raw   = '0;
            err_o = 1'b1;
         end
      endcase
   end

   assign imm_o = XLEN'($signed(raw));

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator with a two-entry skid buffer.
// Ports:
//   clk, rst        clock, async active-high reset
//   flush           drops all buffered entries, wins over every other event
//   in_valid/ready  instruction handshake (in_ready from registered state only)
//   in_instr/sel/tag  instruction, format select, sideband tag
//   out_valid/ready output handshake
//   out_imm/tag/err extended immediate, its tag, illegal-select flag
//
// state    | meaning
// ---------+---------------------------------------------
// ST_EMPTY | no entries, out_valid low
// ST_ONE   | output register holds the oldest entry
// ST_TWO   | output and skid registers full, in_ready low
module imm_gen_pipe
   import imm_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [2:0]       in_sel,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_err
);

   if (!xlen_legal(XLEN)) begin : g_bad_xlen
      $error("imm_gen_pipe: XLEN must be 32 or 64");
   end

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_TWO   = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [XLEN-1:0]  out_imm_q, out_imm_d;
   logic [TAG_W-1:0] out_tag_q, out_tag_d;
   logic             out_err_q, out_err_d;
   logic [XLEN-1:0]  skid_imm_q, skid_imm_d;
   logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
   logic             skid_err_q, skid_err_d;

   logic [XLEN-1:0]  ext_imm;
   logic             ext_err;
   logic             accept;
   logic             deliver;

   imm_extract #(.XLEN(XLEN)) u_extract (
      .instr_i (in_instr),
      .sel_i   (imm_sel_e'(in_sel)),
      .imm_o   (ext_imm),
      .err_o   (ext_err)
   );

   assign in_ready  = !rst && (state_q != ST_TWO);
   assign out_valid = (state_q != ST_EMPTY);
   assign accept    = in_valid && in_ready && !flush;
   assign deliver   = out_valid && out_ready;

   assign out_imm = out_imm_q;
   assign out_tag = out_tag_q;
   assign out_err = out_err_q;

   always_comb begin
      state_d    = state_q;
      out_imm_d  = out_imm_q;
      out_tag_d  = out_tag_q;
      out_err_d  = out_err_q;
      skid_imm_d = skid_imm_q;
      skid_tag_d = skid_tag_q;
      skid_err_d = skid_err_q;
      if (flush) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (accept) begin
                  out_imm_d = ext_imm;
                  out_tag_d = in_tag;
                  out_err_d = ext_err;
                  state_d   = ST_ONE;
               end
            end
            ST_ONE: begin
               if (accept && deliver) begin
                  // new entry replaces the one leaving this edge
                  out_imm_d = ext_imm;
                  out_tag_d = in_tag;
                  out_err_d = ext_err;
               end else if (accept) begin
                  skid_imm_d = ext_imm;
                  skid_tag_d = in_tag;
                  skid_err_d = ext_err;
                  state_d    = ST_TWO;
               end else if (deliver) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_TWO: begin
               if (deliver) begin
                  out_imm_d = skid_imm_q;
                  out_tag_d = skid_tag_q;
                  out_err_d = skid_err_q;
                  state_d   = ST_ONE;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_EMPTY;
         out_imm_q  <= '0;
         out_tag_q  <= '0;
         out_err_q  <= 1'b0;
         skid_imm_q <= '0;
         skid_tag_q <= '0;
         skid_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         out_imm_q  <= out_imm_d;
         out_tag_q  <= out_tag_d;
         out_err_q  <= out_err_d;
         skid_imm_q <= skid_imm_d;
         skid_tag_q <= skid_tag_d;
         skid_err_q <= skid_err_d;
      end
   end

endmodule

// File: tb/tb_imm_gen_pipe.sv
module tb_imm_gen_pipe;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_instr = '0;
   logic [2:0]  in_sel = '0;
   logic [4:0]  in_tag = '0;
   logic        out_ready = 1'b0;

   logic        in_ready32, in_ready64;
   logic        out_valid32, out_valid64;
   logic [31:0] out_imm32;
   logic [63:0] out_imm64;
   logic [4:0]  out_tag32, out_tag64;
   logic        out_err32, out_err64;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   imm_gen_pipe #(.XLEN(32), .TAG_W(5)) u_dut32 (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready32),
      .in_instr(in_instr), .in_sel(in_sel), .in_tag(in_tag),
      .out_valid(out_valid32), .out_ready(out_ready),
      .out_imm(out_imm32), .out_tag(out_tag32), .out_err(out_err32)
   );

   imm_gen_pipe #(.XLEN(64), .TAG_W(5)) u_dut64 (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready64),
      .in_instr(in_instr), .in_sel(in_sel), .in_tag(in_tag),
      .out_valid(out_valid64), .out_ready(out_ready),
      .out_imm(out_imm64), .out_tag(out_tag64), .out_err(out_err64)
   );

   typedef struct {
      logic [63:0] i64;
      logic [63:0] i32;
      logic [4:0]  tag;
      logic        err;
   } exp_t;

   exp_t sb[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference immediate, built from the format rules with integer arithmetic.
   function automatic void ref_imm(input logic [31:0] ins, input logic [2:0] s, input int xlen,
                                   output logic [63:0] imm, output logic err);
      int     si;
      longint v;
      si  = ins;
      err = 1'b0;
      case (s)
         3'd0: v = si >>> 20;
         3'd1: v = (xlen == 64) ? ((si >> 20) & 63) : ((si >> 20) & 31);
         3'd2: v = ((si >>> 25) <<< 5) | ((si >> 7) & 31);
         3'd3: v = ((si >>> 31) <<< 12) | (((si >> 7) & 1) << 11)
                   | (((si >> 25) & 63) << 5) | (((si >> 8) & 15) << 1);
         3'd4: v = si & (~4095);
         3'd5: v = ((si >>> 31) <<< 20) | (((si >> 12) & 255) << 12)
                   | (((si >> 20) & 1) << 11) | (((si >> 21) & 1023) << 1);
         3'd6: v = (si >> 15) & 31;
         default: begin
            v   = 0;
            err = 1'b1;
         end
      endcase
      imm = 64'(v);
      if (xlen == 32) imm = imm & 64'h0000_0000_FFFF_FFFF;
   endfunction

   // Monitor / scoreboard: decides at each falling edge what the next rising
   // edge does, using only the queue occupancy of the reference.
   always @(negedge clk) begin
      int   n;
      exp_t e;
      logic err_tmp;
      if (rst) begin
         chk("rst_out_valid32", {63'b0, out_valid32}, 64'd0);
         chk("rst_out_valid64", {63'b0, out_valid64}, 64'd0);
         chk("rst_in_ready32", {63'b0, in_ready32}, 64'd0);
         chk("rst_in_ready64", {63'b0, in_ready64}, 64'd0);
         chk("rst_out_imm32", {32'b0, out_imm32}, 64'd0);
         chk("rst_out_imm64", out_imm64, 64'd0);
         chk("rst_out_tag", {54'b0, out_tag32, out_tag64}, 64'd0);
         chk("rst_out_err", {62'b0, out_err32, out_err64}, 64'd0);
         sb.delete();
      end else begin
         n = sb.size();
         chk("out_valid32", {63'b0, out_valid32}, {63'b0, (n > 0)});
         chk("out_valid64", {63'b0, out_valid64}, {63'b0, (n > 0)});
         chk("in_ready32", {63'b0, in_ready32}, {63'b0, (n < 2)});
         chk("in_ready64", {63'b0, in_ready64}, {63'b0, (n < 2)});
         if (flush) begin
            sb.delete();
         end else begin
            if (n > 0 && out_ready) begin
               e = sb.pop_front();
               chk("imm32", {32'b0, out_imm32}, e.i32);
               chk("imm64", out_imm64, e.i64);
               chk("tag32", {59'b0, out_tag32}, {59'b0, e.tag});
               chk("tag64", {59'b0, out_tag64}, {59'b0, e.tag});
               chk("err32", {63'b0, out_err32}, {63'b0, e.err});
               chk("err64", {63'b0, out_err64}, {63'b0, e.err});
            end
            if (in_valid && n < 2) begin
               ref_imm(in_instr, in_sel, 32, e.i32, e.err);
               ref_imm(in_instr, in_sel, 64, e.i64, err_tmp);
               e.tag = in_tag;
               sb.push_back(e);
            end
         end
      end
   end

   // Present one instruction and hold it until it is taken.
   task automatic send(input logic [31:0] ins, input logic [2:0] s, input logic [4:0] t);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_instr = ins;
      in_sel   = s;
      in_tag   = t;
      @(negedge clk);
      while (!(in_ready32 && in_ready64) && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         checks++;
         failures++;
         $display("FAIL send_timeout actual=stalled expected=accept tag=%0d", t);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic idle(input int c);
      repeat (c) @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n;
      n = 0;
      out_ready = 1'b1;
      while (sb.size() != 0 && n < 40) begin
         @(posedge clk);
         n++;
      end
      #1;
      if (sb.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain actual=%0d_left expected=0_left", sb.size());
      end
   endtask

   initial begin
      idle(3);
      rst = 1'b0;

      // directed formats, consumer always ready
      out_ready = 1'b1;
      send(32'hFFF00093, 3'b000, 5'd1);
      send(32'hFE000EE3, 3'b011, 5'd2);
      send(32'h80000037, 3'b100, 5'd3);
      send(32'h0080006F, 3'b101, 5'd4);
      send(32'h03F09093, 3'b001, 5'd5);
      send(32'h000FD073, 3'b110, 5'd6);
      send(32'h12345678, 3'b111, 5'd7);
      send(32'h00500093, 3'b000, 5'd8);
      drain();

      // back-pressure: two fill the buffer, third waits for space
      out_ready = 1'b0;
      send(32'h00100093, 3'b000, 5'd1);
      send(32'h00200093, 3'b000, 5'd2);
      fork
         send(32'h00300093, 3'b000, 5'd3);
         begin
            idle(3);
            out_ready = 1'b1;
         end
      join
      drain();

      // flush in TWO and in ONE with a concurrent input
      out_ready = 1'b0;
      send(32'hFFF00093, 3'b000, 5'd9);
      send(32'hFFF00093, 3'b010, 5'd10);
      in_valid = 1'b1; in_sel = 3'b100; in_tag = 5'd11; flush = 1'b1;
      idle(1);
      flush = 1'b0; in_valid = 1'b0;
      idle(1);
      send(32'h80000037, 3'b100, 5'd12);
      in_valid = 1'b1; in_tag = 5'd13; flush = 1'b1;
      idle(1);
      flush = 1'b0; in_valid = 1'b0;
      idle(2);
      drain();

      // randomized traffic, including rare flushes
      for (int i = 0; i < 800; i++) begin
         in_valid  = ($urandom_range(3) != 0);
         out_ready = ($urandom_range(2) != 0);
         in_instr  = $urandom;
         in_sel    = 3'($urandom_range(7));
         in_tag    = 5'($urandom_range(31));
         flush     = ($urandom_range(40) == 0);
         idle(1);
      end
      flush = 1'b0;
      in_valid = 1'b0;
      drain();

      // async reset mid-stream
      out_ready = 1'b0;
      send(32'h0080006F, 3'b101, 5'd20);
      send(32'h03F09093, 3'b001, 5'd21);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_valid", {62'b0, out_valid32, out_valid64}, 64'd0);
      chk("async_rst_ready", {62'b0, in_ready32, in_ready64}, 64'd0);
      idle(2);
      rst = 1'b0;
      out_ready = 1'b1;
      idle(3);
      send(32'hFE000EE3, 3'b011, 5'd22);
      drain();
      idle(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Parametrised, pipelined immediate generator for the decode stage. It takes a full 32-bit instruction and an immediate-format select, and produces the sign- or zero-extended immediate at XLEN width (RV32 or RV64) through a registered valid/ready output. A two-entry skid buffer gives full throughput under back-pressure, and a passthrough tag lets decode match each immediate to its instruction. Illegal selects are flagged rather than silently zeroed.

## Interface
- XLEN, 32, datapath width; legal values 32 or 64 only.
- TAG_W, 5, width of the sideband tag carried alongside each immediate.

- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous; drops all buffered entries.
- in_valid  in  1  instruction presented.
- in_ready  out  1  block can accept this cycle.
- in_instr  in  32  full instruction word.
- in_sel  in  3  immediate format select (imm_sel_e).
- in_tag  in  TAG_W  opaque sideband.
- out_valid  out  1  output entry valid.
- out_ready  in  1  consumer accepts.
- out_imm  out  XLEN  extended immediate.
- out_tag  out  TAG_W  tag of the entry.
- out_err  out  1  entry had an illegal select.

## Operation
- Extraction, sign bit s = instr[31] replicated to XLEN:
  - 000 I: sext(instr[31:20]).
  - 001 I-shift: zext(shamt). shamt = instr[24:20] when XLEN=32, instr[25:20] when XLEN=64.
  - 010 S: sext({instr[31:25], instr[11:7]}).
  - 011 B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - 100 U: sext({instr[31:12], 12'b0}).
  - 101 J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - 110 CSR-imm: zext(instr[19:15]).
  - 111 illegal: imm = 0, err = 1. err is 0 for all other selects.
- Accept on in_valid && in_ready. Deliver on out_valid && out_ready.
- Order is strictly preserved, with no drop or duplication except on flush or rst.
- Occupancy FSM:
  - EMPTY (0 entries): accept → ONE.
  - ONE: accept without deliver → TWO. Deliver without accept → EMPTY. Both → ONE.
  - TWO: deliver → ONE. No accept is possible in TWO.
- The skid entry is promoted to the output register on the same edge as the delivery.
- in_ready = !rst && (state != TWO). It depends only on registered state, never on out_ready.
- flush: next state EMPTY and out_valid = 0. A same-cycle input is not accepted, even if in_ready reads 1. flush takes priority over all other events.
- Unknown XLEN is a compile-time error (elaboration assertion).

## Timing
- Latency: an input accepted at edge N appears on out_* after edge N (valid in cycle N+1).
- Throughput: one per cycle with out_ready held high.
- out_* hold stable while out_valid && !out_ready.
- Reset, async assert and sync deassert by the upstream synchronizer:
  - state EMPTY, out_valid 0, out_imm 0, out_tag 0, out_err 0, in_ready 0 while rst is high.
  - First accept is possible in the first cycle after rst falls.
- Reset mid-operation discards both entries immediately, without waiting for a clock edge.
- Simultaneous accept and deliver in ONE: the new entry replaces the output register and the state stays ONE.

## Structure
- Package imm_pkg:
  - imm_sel_e enum (IMM_I, IMM_ISH, IMM_S, IMM_B, IMM_U, IMM_J, IMM_CSR, IMM_ILL).
  - Instruction bit-field localparams.
  - XLEN legality constants.
- Sub-module imm_extract: purely combinational extraction (instr, sel, XLEN parameter → imm, err). It is instantiated once at the input side, so only raw results are buffered.
- Top imm_gen_pipe holds the output register, the skid register and the 2-bit occupancy FSM.

## Test plan
- I/B formats, XLEN=32, out_ready=1:
  - instr 0xFFF00093, sel 000 → out_imm 0xFFFFFFFF, err 0, one cycle later.
  - instr 0xFE000EE3, sel 011 → 0xFFFFFFFC.
- U/J formats, XLEN=64:
  - instr 0x80000037, sel 100 → 0xFFFFFFFF80000000.
  - instr 0x0080006F, sel 101 → 0x0000000000000008.
- Shift/CSR formats:
  - instr 0x03F09093, sel 001: XLEN=64 → 0x3F; XLEN=32 → 0x1F.
  - instr 0x000FD073, sel 110 → 0x1F.
- Back-pressure: out_ready=0, drive 3 back-to-back inputs with tags 1, 2, 3.
  - Required: tags 1 and 2 accepted, in_ready=0 from the cycle after the 2nd accept.
  - Raise out_ready: outputs tag 1, 2, 3 on consecutive cycles, with the 3rd accepted once in_ready returns.
- Illegal select: sel 111 with any instr → out_imm 0, out_err 1. The next legal entry has out_err 0.
- Flush and reset:
  - In TWO, assert flush with in_valid=1 → next cycle out_valid 0, state EMPTY, input not accepted.
  - Assert rst asynchronously mid-stream → out_valid 0 and in_ready 0 immediately, with no spurious output after release.
